// File: rtl/divisor_seq_pkg.sv
// Shared types and constants for the sequential signed divider (MIPS DIV/DIVU).
package divisor_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                    input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divisor_seq_if.sv
// Start/done handshake and HI/LO result bus between the control unit and the divider.
// DIVISOR_UNSIGNED_EN adds the Unsigned (DIVU) select, sampled with DivIn.
interface divisor_seq_if import divisor_pkg::*; #(parameter int WIDTH = DIV_WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             DivIn;
`ifdef DIVISOR_UNSIGNED_EN
  logic             Unsigned;
`endif
  logic [WIDTH-1:0] resultHigh;
  logic [WIDTH-1:0] resultLow;
  logic             DivOut;
  logic             Div0;

`ifdef DIVISOR_UNSIGNED_EN
  modport master (output A, B, DivIn, Unsigned,
                  input  resultHigh, resultLow, DivOut, Div0);
  modport slave  (input  A, B, DivIn, Unsigned,
                  output resultHigh, resultLow, DivOut, Div0);
`else
  modport master (output A, B, DivIn,
                  input  resultHigh, resultLow, DivOut, Div0);
  modport slave  (input  A, B, DivIn,
                  output resultHigh, resultLow, DivOut, Div0);
`endif

endinterface

// File: rtl/divisor_seq_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module divisor_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  // One extra guard bit so the borrow is exact even for DIVU with a full-range divisor.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_nxt = trial[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor_seq.sv
// Sequential 32-bit divider: remainder to HI, quotient to LO, one bit per cycle.
// Optional DIVISOR_UNSIGNED_EN build adds DIVU support through bus.Unsigned.
//
// state | meaning
// IDLE  | waiting for DivIn; divide-by-zero completes here in one edge
// CALC  | ITER restoring iterations on operand magnitudes
// FIX   | apply quotient/remainder signs, pulse DivOut
module divisor_seq import divisor_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input  logic          clk,
  input  logic          Reset,
  divisor_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  div_state_t state_q, state_d;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             div0_q;

  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic             b_zero;
  logic             uns;
  logic             neg_a;
  logic             neg_b;

  logic             ld_start;
  logic             ld_div0;
  logic             step_en;
  logic             ld_fix;

`ifdef DIVISOR_UNSIGNED_EN
  assign uns = bus.Unsigned;
`else
  assign uns = 1'b0;
`endif

  assign b_zero = (bus.B == '0);
  assign neg_a  = bus.A[WIDTH-1] & ~uns;
  assign neg_b  = bus.B[WIDTH-1] & ~uns;

  divisor_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.DivIn && !b_zero) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(1))   state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_start = 1'b0;
    ld_div0  = 1'b0;
    step_en  = 1'b0;
    ld_fix   = 1'b0;
    case (state_q)
      IDLE: begin
        ld_start = bus.DivIn & ~b_zero;
        ld_div0  = bus.DivIn &  b_zero;
      end
      CALC:    step_en = 1'b1;
      FIX:     ld_fix  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ld_start) begin
        quo_q    <= cond_neg(bus.A, neg_a);
        dvs_q    <= cond_neg(bus.B, neg_b);
        rem_q    <= '0;
        sign_q_q <= neg_a ^ neg_b;
        sign_r_q <= neg_a;
        cnt_q    <= CNT_W'(ITER);
        div0_q   <= 1'b0;
      end
      if (ld_div0) begin
        hi_q   <= bus.A;
        lo_q   <= DIV0_QUOTIENT;
        div0_q <= 1'b1;
        done_q <= 1'b1;
      end
      if (step_en) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
      end
      // Remainder takes the dividend's sign, so the quotient truncates toward zero.
      if (ld_fix) begin
        lo_q   <= cond_neg(quo_q, sign_q_q);
        hi_q   <= cond_neg(rem_q[WIDTH-1:0], sign_r_q);
        done_q <= 1'b1;
        div0_q <= 1'b0;
      end
    end
  end

  assign bus.resultHigh = hi_q;
  assign bus.resultLow  = lo_q;
  assign bus.DivOut     = done_q;
  assign bus.Div0       = div0_q;

endmodule
